// File: rtl/islip_pkg.sv
// Shared types and helpers for the iSLIP round-robin arbiter.
package islip_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOCK  = 2'd2
  } state_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/islip_rr_arbiter_v2_0_rr_pointer_encoder.sv
// Combinational round-robin encoder: lowest request at or above ptr, else lowest request.
module rr_pointer_encoder
  import islip_pkg::*;
#(
  parameter int unsigned N = 32,
  localparam int unsigned PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [N-1:0]     mask;
  logic [N-1:0]     masked;
  logic [PTR_W-1:0] masked_idx;
  logic [PTR_W-1:0] plain_idx;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (PTR_W'(i) >= ptr);
    end
  end

  assign masked = req & mask;

  // Scanning downward lets the lowest set bit win without a break.
  always_comb begin
    masked_idx = '0;
    plain_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (masked[i]) masked_idx = PTR_W'(i);
      if (req[i])    plain_idx  = PTR_W'(i);
    end
  end

  assign any   = |req;
  assign idx   = (|masked) ? masked_idx : plain_idx;
  assign grant = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/islip_rr_arbiter_v2_0.sv
// Registered round-robin arbiter with iSLIP pointer update and optional grant hold.
module islip_rr_arbiter_v2_0
  import islip_pkg::*;
#(
  parameter int unsigned N = 32,
  localparam int unsigned PTR_W = ptr_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_req,
  input  logic             in_valid,
  input  logic             in_accept,
  input  logic             in_hold,
  output logic [N-1:0]     out_grant,
  output logic             out_grant_valid,
  output logic [PTR_W-1:0] out_grant_idx,
  output logic [PTR_W-1:0] out_pointer
);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx_q, idx_d;
  logic [N-1:0]     grant_q, grant_d;
  logic             valid_q, valid_d;

  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] enc_ptr;
  logic [N-1:0]     enc_grant;
  logic [PTR_W-1:0] enc_idx;
  logic             enc_any;
  logic             new_grant;

  assign ptr_inc = (idx_q == PTR_W'(N - 1)) ? '0 : idx_q + PTR_W'(1);

  // An accepted grant arbitrates the next request from the post-accept pointer.
  assign enc_ptr = (state_q == GRANT && in_accept) ? ptr_inc : ptr_q;

  rr_pointer_encoder #(.N(N)) u_enc (
    .req   (in_req),
    .ptr   (enc_ptr),
    .grant (enc_grant),
    .idx   (enc_idx),
    .any   (enc_any)
  );

  assign new_grant = in_valid && enc_any;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (new_grant) begin
          state_d = GRANT;
          grant_d = enc_grant;
          idx_d   = enc_idx;
          valid_d = 1'b1;
        end else begin
          grant_d = '0;
          idx_d   = '0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (in_accept) ptr_d = ptr_inc;
        if (in_accept && in_hold) begin
          state_d = LOCK;
        end else if (new_grant) begin
          grant_d = enc_grant;
          idx_d   = enc_idx;
          valid_d = 1'b1;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
          valid_d = 1'b0;
        end
      end
      LOCK: begin
        if (!(in_hold && in_req[idx_q])) begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign out_grant       = grant_q;
  assign out_grant_valid = valid_q;
  assign out_grant_idx   = idx_q;
  assign out_pointer     = ptr_q;

endmodule

// File: doc/islip_rr_arbiter_v2_0.md
# islip_rr_arbiter_v2_0

Registered, parametrised round-robin arbiter with an iSLIP-style pointer update. It replaces purely combinational programmable-priority encoding with a stateful arbiter: a priority pointer is kept internally and advances only when a grant is accepted. An optional hold mode keeps a grant across multi-cycle transfers. It sits in each iSLIP input/output port scheduler stage, between the request matrix and the accept logic.

## Interface
- N, default 32: number of requesters; N ≥ 2.
- PTR_W, default $clog2(N): pointer and index width. Localparam; never overridden.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_req  input  N  request vector; bit i set means requester i requests.
- in_valid  input  1  arbitration strobe; in_req is sampled only when in_valid=1.
- in_accept  input  1  accept of the current grant; meaningful only while out_grant_valid=1.
- in_hold  input  1  lock request; sampled together with in_accept.
- out_grant  output  N  registered one-hot grant; all zero when out_grant_valid=0.
- out_grant_valid  output  1  out_grant holds a live grant.
- out_grant_idx  output  PTR_W  binary index of the granted bit; 0 when there is no grant.
- out_pointer  output  PTR_W  current priority pointer.

## Operation
- Arbitration function, arb(req, p): the lowest index i ≥ p with req[i]=1. If there is none, the lowest index i with req[i]=1. If req=0, no grant.
- FSM states are IDLE, GRANT and LOCK. Reset state is IDLE.
- IDLE
  - If in_valid and |in_req, register arb(in_req, ptr) and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (out_grant_valid=1, granted index g)
  - in_accept=1: ptr ← (g+1) mod N; g=N-1 wraps to 0.
    - If in_hold=1, go to LOCK and keep the grant.
    - Else if in_valid and |in_req, register arb(in_req, (g+1) mod N) and stay in GRANT. This is a back-to-back grant.
    - Otherwise go to IDLE.
  - in_accept=0: ptr is unchanged and in_hold is ignored.
    - If in_valid and |in_req, register arb(in_req, ptr) and stay in GRANT.
    - Otherwise go to IDLE.
- LOCK
  - The grant is held unchanged; in_valid and in_accept are ignored.
  - Stay while in_hold=1 and in_req[g]=1.
  - Otherwise go to IDLE, which gives a one-cycle bubble before the next grant.
  - ptr does not move while in LOCK.
- The pointer moves only on accept. An unaccepted grant never changes priority, which is the iSLIP desynchronisation property.
- out_grant_idx is the binary encoding of out_grant and is registered with it.

## Timing
- Reset (rst=1 at a clk edge): state=IDLE, ptr=0, out_grant=0, out_grant_valid=0, out_grant_idx=0, out_pointer=0.
- Reset applies mid-GRANT or mid-LOCK with no partial pointer update.
- rst has priority over every other input.
- Grant latency: in_valid/in_req sampled at edge k gives out_grant valid after edge k, i.e. one cycle.
- Throughput is one grant per cycle with back-to-back accept.
- out_pointer reflects an accept on the cycle after the accept edge.
- Simultaneous accept and new request in GRANT: the new grant uses the post-accept pointer, not the stale one.
- in_req changing while in GRANT does not alter the live grant; it only affects the next arbitration.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package islip_pkg holds the FSM state enum (IDLE/GRANT/LOCK) and a clog2-style width helper, if the codebase lacks one.
- The combinational arb() is the natural sub-module, named rr_pointer_encoder: inputs req[N] and ptr[PTR_W], outputs one-hot grant[N], idx[PTR_W] and any.
- rr_pointer_encoder is built as a masked priority encoder plus an unmasked fallback.
- The top level holds the FSM, the pointer register and the output registers.

## Test plan
- **Reset and basic grant (N=4):** rst, then in_valid=1, in_req=4'b1010 → next cycle out_grant=4'b0010, idx=1, out_pointer=0.
- **Accept and wrap:** with ptr=0 and in_req=4'b1000 granted with accept → out_pointer=0, because g=3 wraps.
  - Then in_req=4'b1001 → grant 4'b0001.
- **No accept keeps priority:** ptr=2, in_req=4'b0101 → grant idx=2.
  - in_accept=0 and re-request → idx=2 again, out_pointer stays 2.
- **Back-to-back fairness:** in_req=4'b1111 constant with accept every cycle → idx 0,1,2,3,0 on consecutive cycles, out_grant_valid continuously 1.
- **Hold/LOCK:** accept with in_hold=1 on idx=1 → grant held while in_hold=1 and in_req[1]=1.
  - Drop in_req[1] → one idle cycle, then the next grant starts from pointer 2.
- **Mid-operation reset:** rst asserted in LOCK → next cycle all outputs 0 and state IDLE.
  - The first post-reset grant uses ptr=0.
